// File: rtl/multi_channel_edge_analyzer.sv
// N-channel line-activity analyzer: synchronised edge/level event counting over
// back-to-back fixed windows, with saturation and min/max band pass reporting.
module multi_channel_edge_analyzer #(
    parameter int CHANNELS    = 16,
    parameter int CNT_W       = 12,
    parameter int WINDOW      = 1004,
    parameter int SYNC_STAGES = 2,
    parameter int WIN_CNT_W   = 16
) (
    input  logic                      CLK_100MHz,
    input  logic                      RST_N,
    input  logic                      run,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       line_in,
    input  logic [CNT_W-1:0]          exp_min,
    input  logic [CNT_W-1:0]          exp_max,
    output logic [CHANNELS*CNT_W-1:0] cnt_flat,
    output logic [CHANNELS-1:0]       pass_mask,
    output logic [CHANNELS-1:0]       sat_mask,
    output logic                      result_valid,
    output logic [WIN_CNT_W-1:0]      win_seq,
    output logic                      busy
);

    localparam int IDX_W = $clog2(WINDOW);
    localparam int SET_W = $clog2(SYNC_STAGES + 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WINDOW - 1);
    localparam logic [SET_W-1:0] SETTLE_LEN = SET_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2
    } state_t;

    state_t                state;
    logic [SET_W-1:0]      settle_cnt;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            mode_r;
    logic [CNT_W-1:0]      cnt     [CHANNELS];
    logic [CHANNELS-1:0]   sat;

    logic [CHANNELS-1:0]   sync_p  [SYNC_STAGES];
    logic [CHANNELS-1:0]   line_s;
    logic [CHANNELS-1:0]   line_s_d;
    logic [CHANNELS-1:0]   rise;
    logic [CHANNELS-1:0]   fall;
    logic [CHANNELS-1:0]   evt;
    logic [CNT_W-1:0]      cnt_inc [CHANNELS];
    logic [CHANNELS-1:0]   sat_next;
    logic [CHANNELS-1:0]   in_band;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
            line_s_d <= '0;
        end else begin
            sync_p[0] <= line_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
            line_s_d <= line_s;
        end
    end

    assign line_s = sync_p[SYNC_STAGES-1];
    assign rise   = line_s & ~line_s_d;
    assign fall   = ~line_s & line_s_d;

    always_comb begin
        evt = '0;
        unique case (mode_r)
            2'b00:   evt = rise | fall;
            2'b01:   evt = rise;
            2'b10:   evt = fall;
            default: evt = line_s;
        endcase
    end

    // Saturating increment; the window-end result includes this cycle's event
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_inc[i]  = cnt[i];
            sat_next[i] = sat[i];
            if (evt[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    sat_next[i] = 1'b1;
                end else begin
                    cnt_inc[i] = cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            in_band[i] = (cnt_inc[i] >= exp_min) && (cnt_inc[i] <= exp_max);
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            idx          <= '0;
            mode_r       <= 2'b00;
            sat          <= '0;
            cnt_flat     <= '0;
            pass_mask    <= '0;
            sat_mask     <= '0;
            result_valid <= 1'b0;
            win_seq      <= '0;
            busy         <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    sat <= '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        cnt[i] <= '0;
                    end
                    if (run) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LEN;
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (settle_cnt == SET_W'(1)) begin
                        state  <= COUNT;
                        idx    <= '0;
                        mode_r <= mode;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                COUNT: begin
                    if (!run) begin
                        // Partial window is discarded; published results hold
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                        sat   <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt[i] <= '0;
                        end
                    end else if (idx == IDX_LAST) begin
                        idx          <= '0;
                        mode_r       <= mode;
                        sat          <= '0;
                        sat_mask     <= sat_next;
                        pass_mask    <= in_band & ~sat_next;
                        result_valid <= 1'b1;
                        win_seq      <= win_seq + WIN_CNT_W'(1);
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt_flat[i*CNT_W +: CNT_W] <= cnt_inc[i];
                            cnt[i]                     <= '0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        sat <= sat_next;
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt[i] <= cnt_inc[i];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_edge_analyzer.sv
// Directed bench: a 6-bit-counter instance for band/mode checks and a 4-bit-counter
// instance sharing the same stimulus for saturation checks.
module tb_multi_channel_edge_analyzer;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        run;
    logic [1:0]  mode;
    logic [3:0]  line_in = '0;
    logic [5:0]  exp_min, exp_max;
    logic [23:0] cnt_flat;
    logic [3:0]  pass_mask, sat_mask;
    logic        result_valid;
    logic [15:0] win_seq;
    logic        busy;

    logic [3:0]  exp_min2, exp_max2;
    logic [15:0] cnt_flat2;
    logic [3:0]  pass_mask2, sat_mask2;
    logic        result_valid2;
    logic [15:0] win_seq2;
    logic        busy2;

    int pat;
    int phase = 0;
    int checks = 0;
    int passes = 0;

    localparam logic [23:0] CNT_P1 = {6'd10, 6'd0, 6'd0, 6'd20};

    multi_channel_edge_analyzer #(
        .CHANNELS(4), .CNT_W(6), .WINDOW(20), .SYNC_STAGES(2), .WIN_CNT_W(16)
    ) dut (
        .CLK_100MHz(clk), .RST_N(RST_N), .run(run), .mode(mode), .line_in(line_in),
        .exp_min(exp_min), .exp_max(exp_max), .cnt_flat(cnt_flat), .pass_mask(pass_mask),
        .sat_mask(sat_mask), .result_valid(result_valid), .win_seq(win_seq), .busy(busy)
    );

    multi_channel_edge_analyzer #(
        .CHANNELS(4), .CNT_W(4), .WINDOW(20), .SYNC_STAGES(2), .WIN_CNT_W(16)
    ) dut_sat (
        .CLK_100MHz(clk), .RST_N(RST_N), .run(run), .mode(mode), .line_in(line_in),
        .exp_min(exp_min2), .exp_max(exp_max2), .cnt_flat(cnt_flat2), .pass_mask(pass_mask2),
        .sat_mask(sat_mask2), .result_valid(result_valid2), .win_seq(win_seq2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // pat 1: ch0 toggles every cycle, ch1=0, ch2=1, ch3 toggles every 2 cycles
    // pat 2: ch0 square wave of period 4
    always @(negedge clk) begin
        phase = phase + 1;
        case (pat)
            1:       line_in = {phase[1], 1'b1, 1'b0, phase[0]};
            2:       line_in = {3'b000, phase[1]};
            default: line_in = 4'b0000;
        endcase
    end

    task automatic wait_result(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            if (result_valid) seen = 1'b1;
        end
    endtask

    task automatic restart(input int p, input logic [1:0] m);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pat  = p;
        mode = m;
        run  = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cnt_flat !== 24'd0 || pass_mask !== 4'd0 || sat_mask !== 4'd0 ||
            result_valid !== 1'b0 || win_seq !== 16'd0 || busy !== 1'b0)
            $display("FAIL reset_outputs: cnt=%h pass=%b sat=%b rv=%b seq=%0d busy=%b, required all 0",
                     cnt_flat, pass_mask, sat_mask, result_valid, win_seq, busy);
        else passes++;
        RST_N = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || win_seq !== 16'd0)
            $display("FAIL idle_quiet: busy=%b rv=%b seq=%0d, required 0/0/0", busy, result_valid, win_seq);
        else passes++;
    endtask

    task automatic test_mode_both();
        int cyc;
        bit seen;
        restart(1, 2'b00);
        for (int w = 1; w <= 3; w++) begin
            wait_result(60, cyc, seen);
            checks++;
            if (!seen || cyc != ((w == 1) ? 24 : 20))
                $display("FAIL both_timing w%0d: seen=%b cycles=%0d, required %0d", w, seen, cyc,
                         (w == 1) ? 24 : 20);
            else passes++;
            checks++;
            if (cnt_flat !== CNT_P1)
                $display("FAIL both_counts w%0d: got %h, required %h", w, cnt_flat, CNT_P1);
            else passes++;
            checks++;
            if (pass_mask !== 4'b0001 || sat_mask !== 4'b0000)
                $display("FAIL both_masks w%0d: pass=%b sat=%b, required 0001/0000", w, pass_mask, sat_mask);
            else passes++;
            checks++;
            if (win_seq !== 16'(w))
                $display("FAIL both_win_seq w%0d: got %0d, required %0d", w, win_seq, w);
            else passes++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_valid !== 1'b0)
            $display("FAIL valid_pulse: got %b, required 0", result_valid);
        else passes++;
    endtask

    task automatic test_saturation();
        int cyc;
        bit seen;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || result_valid2 !== 1'b1)
            $display("FAIL sat_result_seen: seen=%b rv2=%b, required 1/1", seen, result_valid2);
        else passes++;
        checks++;
        if (cnt_flat2 !== {4'd10, 4'd0, 4'd0, 4'd15})
            $display("FAIL sat_counts: got %h, required %h", cnt_flat2, {4'd10, 4'd0, 4'd0, 4'd15});
        else passes++;
        checks++;
        if (sat_mask2 !== 4'b0001 || pass_mask2 !== 4'b1110)
            $display("FAIL sat_masks: sat=%b pass=%b, required 0001/1110", sat_mask2, pass_mask2);
        else passes++;
    endtask

    task automatic test_edge_modes();
        int cyc;
        bit seen;
        logic [1:0]  mlist [3] = '{2'b01, 2'b10, 2'b11};
        logic [23:0] elist [3] = '{24'd5, 24'd5, 24'd10};
        for (int k = 0; k < 3; k++) begin
            restart(2, mlist[k]);
            wait_result(60, cyc, seen);
            checks++;
            if (!seen || cnt_flat !== elist[k])
                $display("FAIL mode%0d_count: seen=%b got %h, required %h", mlist[k], seen, cnt_flat, elist[k]);
            else passes++;
        end
        // still running in mode 11: switch to rising mid-window
        repeat (10) @(posedge clk);
        #1;
        mode = 2'b01;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || cnt_flat !== 24'd10)
            $display("FAIL midwin_unchanged: seen=%b got %h, required %h", seen, cnt_flat, 24'd10);
        else passes++;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || cnt_flat !== 24'd5)
            $display("FAIL midwin_next: seen=%b got %h, required %h", seen, cnt_flat, 24'd5);
        else passes++;
    endtask

    task automatic test_run_drop();
        int cyc;
        bit seen;
        int pulses;
        logic [23:0] cnt_saved;
        logic [15:0] seq_saved;
        restart(1, 2'b00);
        wait_result(60, cyc, seen);
        cnt_saved = cnt_flat;
        seq_saved = win_seq;
        checks++;
        if (!seen || cnt_saved !== CNT_P1)
            $display("FAIL drop_first: seen=%b got %h, required %h", seen, cnt_saved, CNT_P1);
        else passes++;
        repeat (10) @(posedge clk);
        #1;
        run = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        checks++;
        if (pulses != 0)
            $display("FAIL drop_no_valid: got %0d pulses, required 0", pulses);
        else passes++;
        checks++;
        if (cnt_flat !== cnt_saved || win_seq !== seq_saved || busy !== 1'b0)
            $display("FAIL drop_hold: cnt=%h seq=%0d busy=%b, required %h/%0d/0",
                     cnt_flat, win_seq, busy, cnt_saved, seq_saved);
        else passes++;
        run = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1)
            $display("FAIL rerun_busy: got %b, required 1", busy);
        else passes++;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || cyc != 23)
            $display("FAIL rerun_latency: seen=%b cycles=%0d, required 23 after first edge", seen, cyc);
        else passes++;
        checks++;
        if (win_seq !== seq_saved + 16'd1 || cnt_flat !== CNT_P1)
            $display("FAIL rerun_result: seq=%0d cnt=%h, required %0d/%h",
                     win_seq, cnt_flat, seq_saved + 16'd1, CNT_P1);
        else passes++;
    endtask

    task automatic test_async_reset();
        int cyc;
        bit seen;
        repeat (7) @(posedge clk);
        #3;
        RST_N = 1'b0;
        #1;
        checks++;
        if (cnt_flat !== 24'd0 || pass_mask !== 4'd0 || sat_mask !== 4'd0 ||
            result_valid !== 1'b0 || win_seq !== 16'd0 || busy !== 1'b0)
            $display("FAIL async_reset: cnt=%h pass=%b sat=%b rv=%b seq=%0d busy=%b, required all 0",
                     cnt_flat, pass_mask, sat_mask, result_valid, win_seq, busy);
        else passes++;
        @(posedge clk);
        #3;
        RST_N = 1'b1;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || cyc != 24)
            $display("FAIL post_reset_latency: seen=%b cycles=%0d, required 24", seen, cyc);
        else passes++;
        checks++;
        if (win_seq !== 16'd1 || cnt_flat !== CNT_P1 || pass_mask !== 4'b0001)
            $display("FAIL post_reset_result: seq=%0d cnt=%h pass=%b, required 1/%h/0001",
                     win_seq, cnt_flat, pass_mask, CNT_P1);
        else passes++;
    endtask

    task automatic test_inverted_band();
        int cyc;
        bit seen;
        exp_min = 6'd30;
        exp_max = 6'd10;
        wait_result(60, cyc, seen);
        checks++;
        if (!seen || cnt_flat !== CNT_P1)
            $display("FAIL inv_band_count: seen=%b got %h, required %h", seen, cnt_flat, CNT_P1);
        else passes++;
        checks++;
        if (pass_mask !== 4'b0000)
            $display("FAIL inv_band_pass: got %b, required 0000", pass_mask);
        else passes++;
    endtask

    initial begin
        RST_N    = 1'b0;
        run      = 1'b0;
        mode     = 2'b00;
        pat      = 0;
        exp_min  = 6'd18;
        exp_max  = 6'd22;
        exp_min2 = 4'd0;
        exp_max2 = 4'd15;
        test_reset();
        test_mode_both();
        test_saturation();
        test_edge_modes();
        test_run_drop();
        test_async_reset();
        test_inverted_band();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_edge_analyzer.md
Name: multi_channel_edge_analyzer

Overview:
Parametrised N-channel line-activity analyzer for the channel self-check path. Each input line passes through a synchroniser. Per channel, the block counts edge or level events over back-to-back windows of fixed length. At every window end it latches all counts, compares each against an expected min/max band, and publishes a per-channel pass mask with a one-cycle valid strobe. It generalises the earlier single-wire P/N skew counter to CHANNELS lines and selectable event modes, and adds saturation and pass/fail reporting.

Parameters:
CHANNELS, 16, number of monitored lines
CNT_W, 12, per-channel counter/result width
WINDOW, 1004, window length in clock cycles (>=2)
SYNC_STAGES, 2, synchroniser depth (>=2)
WIN_CNT_W, 16, width of window sequence counter

Ports:
CLK_100MHz  in  1  system clock
RST_N  in  1  asynchronous active-low reset
run  in  1  1 = analyze continuously; 0 = idle
mode  in  2  00 both edges, 01 rising, 10 falling, 11 cycles-high
line_in  in  CHANNELS  asynchronous monitored lines
exp_min  in  CNT_W  lower pass bound (inclusive), shared by all channels
exp_max  in  CNT_W  upper pass bound (inclusive)
cnt_flat  out  CHANNELS*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
pass_mask  out  CHANNELS  bit i = channel i last count in band and not saturated
sat_mask  out  CHANNELS  bit i = channel i saturated in last window
result_valid  out  1  one-cycle pulse when results update
win_seq  out  WIN_CNT_W  completed-window count, wraps modulo 2^WIN_CNT_W
busy  out  1  high in SETTLE or COUNT

Behaviour:
- Reset (async, RST_N=0): all flops cleared. Sync chains, counters, cnt_flat, pass_mask, sat_mask, result_valid, win_seq and busy = 0. State = IDLE.
- Sync: line_in goes through SYNC_STAGES flops to give s. A one-cycle-delayed copy s_d feeds edge detection. rise = s & ~s_d, fall = ~s & s_d. Event per mode: both = rise|fall; 11 = s.
- Latency: a line_in transition is counted SYNC_STAGES+1 cycles after it occurs.
- FSM:
  - IDLE: counters held at 0. On run=1, go to SETTLE and load the settle counter with SYNC_STAGES+1.
  - SETTLE: no counting. The stale synchroniser history flushes. When the settle counter expires, go to COUNT with the window index = 0, and sample mode into mode_r.
  - COUNT: window index runs 0..WINDOW-1. Each cycle, each channel counter += event(mode_r), saturating at 2^CNT_W-1. Saturation sets a per-channel sat flag.
  - Window end (index WINDOW-1), same cycle:
    - cnt_flat takes counter + this cycle's event (saturating); sat_mask takes the sat flags.
    - pass_mask[i] = (exp_min <= result_i <= exp_max) & ~sat_i.
    - Counters and sat flags clear to 0, the index wraps to 0, and mode_r re-samples mode.
    - Registered outputs are visible, with result_valid=1 and win_seq+1, on the next cycle.
  - Windows are back-to-back with no gap cycles. Every COUNT cycle belongs to exactly one window.
- run=0 in SETTLE or COUNT: go to IDLE on the next edge and discard the partial window. No result_valid. Outputs hold their last values.
- exp_min > exp_max: pass_mask = 0 for all channels.
- mode changes mid-window are ignored until the next window start.
- result_valid is a single-cycle pulse and is never asserted outside COUNT-derived window ends.
- Area: CHANNELS counters of CNT_W bits plus one shared index counter of $clog2(WINDOW) bits.

Test Plan:
Bench parameters unless noted: CHANNELS=4, CNT_W=6, WINDOW=20, SYNC_STAGES=2, exp_min=18, exp_max=22.
1. ch0 toggles every cycle, ch1=0, ch2=1, ch3 toggles every 2 cycles; mode=00 -> counts {20,0,0,10}; pass_mask=0001; result_valid every 20 cycles; win_seq 1,2,3.
2. ch0 square wave, period 4 (2 high/2 low); mode 01 / 10 / 11 in successive runs -> 5 / 5 / 10 per window. A mode change mid-window takes effect only in the following window's result.
3. CNT_W=4, ch0 toggling every cycle, mode=00 -> count 15, sat_mask[0]=1, pass_mask[0]=0 even with exp_min=0, exp_max=15.
4. After one result, drop run at window index 10 -> no further result_valid; cnt_flat and win_seq hold. Re-raise run -> busy=1, 3 SETTLE cycles, then the first fresh result arrives exactly 3+20 cycles (+1 register) after the run edge.
5. Pull RST_N low at window index 7 -> all outputs 0 asynchronously, before the next clock edge. Release with run=1 -> normal SETTLE then COUNT sequence.
6. exp_min=30, exp_max=10, ch0 toggling -> count 20, pass_mask=0000.
